// File: rtl/commit_retire_ctrl.sv
// Commit/retire controller: retirement RAT plus a release FIFO of superseded physical registers.
// Optional build macro RETIRE_INSTRET_EN adds a 64-bit retired-instruction counter output.
module commit_retire_ctrl #(
  parameter int unsigned DISPATCH_WIDTH       = 2,
  parameter int unsigned PHYS_REGS_ADDR_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH           = 8
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [DISPATCH_WIDTH-1:0]                          commit_en,
  input  logic [DISPATCH_WIDTH-1:0][4:0]                     commit_arch_rd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd,
  output logic                                               commit_ready,
  output logic                                               free_valid,
  output logic [PHYS_REGS_ADDR_WIDTH-1:0]                    free_phys,
  input  logic                                               free_ready
`ifdef RETIRE_INSTRET_EN
  ,
  output logic [63:0]                                        instret
`endif
);

  localparam int unsigned PHYS_W    = PHYS_REGS_ADDR_WIDTH;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W     = PTR_W + 1;
  localparam int unsigned CNT_W     = $clog2(DISPATCH_WIDTH + 1);
  localparam int unsigned ARCH_REGS = 32;

  logic [PHYS_W-1:0]         r_rat  [ARCH_REGS];
  logic [PHYS_W-1:0]         r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wptr;
  logic [PTR_W-1:0]          r_rptr;
  logic [OCC_W-1:0]          r_occ;

  logic [DISPATCH_WIDTH-1:0] w_accept;
  logic [DISPATCH_WIDTH-1:0] w_push;
  logic [PHYS_W-1:0]         w_old  [DISPATCH_WIDTH];
  logic [PTR_W-1:0]          w_widx [DISPATCH_WIDTH];
  logic [CNT_W-1:0]          w_push_cnt;
  logic [PHYS_W-1:0]         w_rat_next [ARCH_REGS];
  logic                      w_pop;

  // Worst case every lane pushes, so leave room for a full group before accepting.
  assign commit_ready = (r_occ <= OCC_W'(FIFO_DEPTH - DISPATCH_WIDTH));
  assign w_accept     = commit_en & {DISPATCH_WIDTH{commit_ready}};
  assign free_valid   = (r_occ != '0);
  assign free_phys    = free_valid ? r_fifo[r_rptr] : '0;
  assign w_pop        = free_valid & free_ready;

  // Lanes walk in index order against a running RAT copy, so a later lane to the
  // same arch reg releases the earlier lane's mapping; pushes are compacted.
  always_comb begin
    w_rat_next = r_rat;
    w_push     = '0;
    w_push_cnt = '0;
    for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
      w_old[k]  = w_rat_next[commit_arch_rd[k]];
      w_widx[k] = r_wptr + PTR_W'(w_push_cnt);
      if (w_accept[k] && (commit_arch_rd[k] != 5'd0)) begin
        w_push[k]                      = 1'b1;
        w_rat_next[commit_arch_rd[k]]  = commit_phys_rd[k];
        w_push_cnt                     = w_push_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) begin
        r_rat[i] <= PHYS_W'(i);
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      r_rat  <= w_rat_next;
      r_wptr <= r_wptr + PTR_W'(w_push_cnt);
      r_rptr <= r_rptr + PTR_W'(w_pop);
      r_occ  <= r_occ + OCC_W'(w_push_cnt) - OCC_W'(w_pop);
    end
  end

  // Storage needs no reset: entries are only observed while occupancy covers them.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
      if (w_push[k]) begin
        r_fifo[w_widx[k]] <= w_old[k];
      end
    end
  end

`ifdef RETIRE_INSTRET_EN
  logic [CNT_W-1:0] w_accept_cnt;

  always_comb begin
    w_accept_cnt = '0;
    for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
      w_accept_cnt = w_accept_cnt + CNT_W'(w_accept[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else begin
      instret <= instret + 64'(w_accept_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_commit_retire_ctrl.sv
// Directed self-checking bench for commit_retire_ctrl (DISPATCH_WIDTH=2, PHYS=6, FIFO_DEPTH=8).
module tb_commit_retire_ctrl;

  logic            clk;
  logic            rst_n;
  logic [1:0]      commit_en;
  logic [1:0][4:0] commit_arch_rd;
  logic [1:0][5:0] commit_phys_rd;
  logic            commit_ready;
  logic            free_valid;
  logic [5:0]      free_phys;
  logic            free_ready;
`ifdef RETIRE_INSTRET_EN
  logic [63:0]     instret;
`endif

  int checks = 0;
  int errors = 0;

  commit_retire_ctrl #(
    .DISPATCH_WIDTH(2),
    .PHYS_REGS_ADDR_WIDTH(6),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .commit_en(commit_en),
    .commit_arch_rd(commit_arch_rd),
    .commit_phys_rd(commit_phys_rd),
    .commit_ready(commit_ready),
    .free_valid(free_valid),
    .free_phys(free_phys),
    .free_ready(free_ready)
`ifdef RETIRE_INSTRET_EN
    ,
    .instret(instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of commit requests; inputs change 1ns after the edge.
  task automatic commit(input logic [1:0] en, input logic [4:0] a0, input logic [5:0] p0,
                        input logic [4:0] a1, input logic [5:0] p1);
    commit_en         = en;
    commit_arch_rd[0] = a0;
    commit_phys_rd[0] = p0;
    commit_arch_rd[1] = a1;
    commit_phys_rd[1] = p1;
    @(posedge clk);
    #1;
    commit_en = 2'b00;
  endtask

  // Check the head, then pop it over one cycle.
  task automatic pop_check(input string tag, input logic [5:0] exp);
    chk({tag, "_valid"}, 64'(free_valid), 64'd1);
    chk({tag, "_phys"}, 64'(free_phys), 64'(exp));
    free_ready = 1'b1;
    @(posedge clk);
    #1;
    free_ready = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    commit_en      = 2'b00;
    commit_arch_rd = '0;
    commit_phys_rd = '0;
    free_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(commit_ready), 64'd1);
    chk("rst_valid", 64'(free_valid), 64'd0);
    chk("rst_phys", 64'(free_phys), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single commit arch5 -> 40 releases identity mapping 5
    commit(2'b01, 5'd5, 6'd40, 5'd0, 6'd0);
    chk("c1_valid", 64'(free_valid), 64'd1);
    chk("c1_phys", 64'(free_phys), 64'd5);
    pop_check("c1_pop", 6'd5);
    chk("c1_empty", 64'(free_valid), 64'd0);
    commit(2'b01, 5'd5, 6'd41, 5'd0, 6'd0);
    pop_check("rat5", 6'd40);

    // Same-cycle collision on arch7
    commit(2'b11, 5'd7, 6'd33, 5'd7, 6'd34);
    pop_check("coll_first", 6'd7);
    pop_check("coll_second", 6'd33);
    chk("coll_empty", 64'(free_valid), 64'd0);
    commit(2'b01, 5'd7, 6'd35, 5'd0, 6'd0);
    pop_check("rat7", 6'd34);

    // Lane0 to arch0 is skipped, lane1 compacts into the first slot
    commit(2'b11, 5'd0, 6'd50, 5'd3, 6'd51);
    pop_check("x0_only3", 6'd3);
    chk("x0_empty", 64'(free_valid), 64'd0);

    // Fill without popping; pointers start at 6 so this wraps
    commit(2'b11, 5'd10, 6'd20, 5'd11, 6'd21);
    commit(2'b11, 5'd12, 6'd22, 5'd13, 6'd23);
    chk("occ4_ready", 64'(commit_ready), 64'd1);
    commit(2'b11, 5'd14, 6'd24, 5'd15, 6'd25);
    chk("occ6_ready", 64'(commit_ready), 64'd1);
    chk("occ6_head", 64'(free_phys), 64'd10);

    // Pop and two pushes together: occupancy 6 -> 7
    free_ready = 1'b1;
    commit(2'b11, 5'd16, 6'd26, 5'd17, 6'd27);
    free_ready = 1'b0;
    chk("occ7_ready", 64'(commit_ready), 64'd0);
    chk("occ7_head", 64'(free_phys), 64'd11);

    // Commits while not ready must be ignored
    commit(2'b11, 5'd5, 6'd60, 5'd7, 6'd61);
    chk("ign_ready", 64'(commit_ready), 64'd0);
    chk("ign_head", 64'(free_phys), 64'd11);

    pop_check("drain0", 6'd11);
    chk("drain_ready", 64'(commit_ready), 64'd1);
    pop_check("drain1", 6'd12);
    pop_check("drain2", 6'd13);
    pop_check("drain3", 6'd14);
    pop_check("drain4", 6'd15);
    pop_check("drain5", 6'd16);
    pop_check("drain6", 6'd17);
    chk("drain_empty", 64'(free_valid), 64'd0);

    // The ignored commit left arch5 mapped to 41
    commit(2'b01, 5'd5, 6'd42, 5'd0, 6'd0);
    pop_check("ign_rat5", 6'd41);

    // Queue 4 entries, then assert reset mid-cycle with a commit pending
    commit(2'b11, 5'd20, 6'd30, 5'd21, 6'd31);
    commit(2'b11, 5'd22, 6'd32, 5'd23, 6'd33);
    chk("pre_rst_head", 64'(free_phys), 64'd20);
    commit_en         = 2'b11;
    commit_arch_rd[0] = 5'd24;
    commit_phys_rd[0] = 6'd34;
    commit_arch_rd[1] = 5'd25;
    commit_phys_rd[1] = 6'd35;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(free_valid), 64'd0);
    chk("mid_rst_phys", 64'(free_phys), 64'd0);
    chk("mid_rst_ready", 64'(commit_ready), 64'd1);
    @(posedge clk);
    #1;
    commit_en = 2'b00;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(free_valid), 64'd0);

    // RAT back to identity; three accepted lanes including an arch0 lane
    commit(2'b11, 5'd20, 6'd40, 5'd22, 6'd41);
    commit(2'b01, 5'd0, 6'd42, 5'd0, 6'd0);
`ifdef RETIRE_INSTRET_EN
    chk("instret3", instret, 64'd3);
`endif
    pop_check("rst_rat20", 6'd20);
    pop_check("rst_rat22", 6'd22);
    chk("final_empty", 64'(free_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
